// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the instruction/data memory arbiter.
//   resp_owner_e : which requester owns the read response due next cycle
//   arb_state_e  : which requester currently holds priority
//   STREAK_W     : width of the consecutive-data-grant counter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_INS,
        OWNER_DATA
    } resp_owner_e;

    typedef enum logic {
        PRIO_DATA,
        PRIO_INS
    } arb_state_e;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter
// Shares one single-port synchronous memory (1-cycle read latency) between
// the instruction-fetch port and the load/store port. One access per cycle;
// the data port normally wins, but after MAX_DATA_STREAK consecutive data
// grants with fetch waiting, fetch is forced through for one grant.
// Read responses are routed back to the owning port one cycle after grant.
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   ins_req_i/ins_addr_i          fetch request and word address
//   ins_gnt_o                     fetch accepted this cycle
//   ins_flush_i                   drop a fetch response due this cycle
//   ins_rvalid_o/ins_rdata_o      fetch response
//   data_req_i/we/be/addr/wdata   load/store request
//   data_gnt_o                    load/store accepted this cycle
//   data_rvalid_o/data_rdata_o    load response
//   mem_en_o/we_o/addr_o/wdata_o  memory command
//   mem_rdata_i                   memory read data (cycle after a read)
// ---------------------------------------------------------------------------
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned  MAX_DATA_STREAK = 4,
    parameter logic [31:0]  RESET_ADDR      = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ins_req_i,
    input  logic [31:0] ins_addr_i,
    output logic        ins_gnt_o,
    input  logic        ins_flush_i,
    output logic        ins_rvalid_o,
    output logic [31:0] ins_rdata_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_e            state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    resp_owner_e           owner_q, owner_d;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic                  ins_gnt, data_gnt;

    // Grant selection, streak counting and priority hand-off.
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        ins_gnt  = 1'b0;
        data_gnt = 1'b0;
        state_d  = state_q;
        streak_d = streak_q;

        // Grants are held off while reset is asserted.
        if (!rst_i) begin
            case (state_q)
                PRIO_DATA: begin
                    data_gnt = data_req_i;
                    ins_gnt  = ins_req_i & ~data_req_i;
                    if (!ins_req_i || ins_gnt) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        // Fetch is waiting behind a data grant; saturate.
                        streak_d = streak_q + STREAK_W'(1);
                    end
                    if (ins_req_i && data_gnt && streak_d == STREAK_MAX) begin
                        state_d = PRIO_INS;
                    end
                end
                PRIO_INS: begin
                    ins_gnt  = ins_req_i;
                    data_gnt = data_req_i & ~ins_req_i;
                    // Either fetch gets its one grant or it no longer waits.
                    state_d  = PRIO_DATA;
                    streak_d = '0;
                end
                default: begin
                    state_d  = PRIO_DATA;
                    streak_d = '0;
                end
            endcase
        end
    end

    // Response ownership for the access issued this cycle.
    always_comb begin
        owner_d = OWNER_NONE;
        if (ins_gnt) begin
            owner_d = OWNER_INS;
        end else if (data_gnt && !data_we_i) begin
            owner_d = OWNER_DATA;
        end
    end

    // Memory command; address and write data hold their last value when idle.
    assign mem_en_o    = ins_gnt | data_gnt;
    assign mem_we_o    = (data_gnt && data_we_i) ? data_be_i : 4'b0000;
    assign mem_addr_o  = ins_gnt  ? ins_addr_i  :
                         data_gnt ? data_addr_i : addr_q;
    assign mem_wdata_o = data_gnt ? data_wdata_i : wdata_q;

    assign ins_gnt_o  = ins_gnt;
    assign data_gnt_o = data_gnt;

    // A flush only discards a fetch response that is due this cycle.
    assign ins_rvalid_o  = (owner_q == OWNER_INS) && !ins_flush_i;
    assign data_rvalid_o = (owner_q == OWNER_DATA);
    assign ins_rdata_o   = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= PRIO_DATA;
            streak_q <= '0;
            owner_q  <= OWNER_NONE;
            addr_q   <= RESET_ADDR;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            owner_q  <= owner_d;
            addr_q   <= mem_addr_o;
            wdata_q  <= mem_wdata_o;
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_dmem_arbiter
// Self-checking bench for imem_dmem_arbiter. A behavioural memory answers
// the DUT's memory port; a separate reference model (streak count, pending
// response, golden memory image) predicts grants, memory command and
// routed responses from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_imem_dmem_arbiter;

    localparam int          MAX      = 4;
    localparam logic [31:0] RST_ADDR = 32'h8000_0000;

    logic        clk_i, rst_i;
    logic        ins_req_i, ins_flush_i;
    logic [31:0] ins_addr_i;
    logic        ins_gnt_o, ins_rvalid_o;
    logic [31:0] ins_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;

    imem_dmem_arbiter #(
        .MAX_DATA_STREAK (MAX),
        .RESET_ADDR      (RST_ADDR)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ins_req_i     (ins_req_i),
        .ins_addr_i    (ins_addr_i),
        .ins_gnt_o     (ins_gnt_o),
        .ins_flush_i   (ins_flush_i),
        .ins_rvalid_o  (ins_rvalid_o),
        .ins_rdata_o   (ins_rdata_o),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .mem_en_o      (mem_en_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Unwritten words read back as a fixed function of their address.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------- behavioural memory driven by the DUT ----------------
    logic [31:0] env_mem [bit [29:0]];
    logic [31:0] env_w;
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            env_w = env_mem.exists(mem_addr_o[31:2]) ? env_mem[mem_addr_o[31:2]]
                                                     : init_word(mem_addr_o);
            if (mem_we_o != 4'b0000) env_mem[mem_addr_o[31:2]] = merge(env_w, mem_wdata_o, mem_we_o);
            else                     mem_rdata_i <= env_w;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [bit [29:0]];
    int          ref_streak;   // data grants in a row while fetch waited
    int          pend_owner;   // 0 none, 1 fetch, 2 load
    logic [31:0] pend_rdata, last_addr, last_wdata;

    logic        exp_ins_gnt, exp_data_gnt, exp_en, exp_ins_rvalid, exp_data_rvalid;
    logic [3:0]  exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a);
    endfunction

    task automatic model_reset();
        ref_streak = 0;
        pend_owner = 0;
        last_addr  = RST_ADDR;
        last_wdata = 32'h0;
    endtask

    task automatic model_eval();
        exp_ins_gnt     = ins_req_i && (!data_req_i || ref_streak >= MAX);
        exp_data_gnt    = data_req_i && !exp_ins_gnt;
        exp_en          = exp_ins_gnt || exp_data_gnt;
        exp_we          = (exp_data_gnt && data_we_i) ? data_be_i : 4'h0;
        exp_addr        = exp_ins_gnt ? ins_addr_i : (exp_data_gnt ? data_addr_i : last_addr);
        exp_wdata       = exp_data_gnt ? data_wdata_i : last_wdata;
        exp_ins_rvalid  = (pend_owner == 1) && !ins_flush_i;
        exp_data_rvalid = (pend_owner == 2);
        exp_rdata       = pend_rdata;
    endtask

    task automatic model_commit();
        if (exp_ins_gnt || !ins_req_i) ref_streak = 0;
        else if (exp_data_gnt)         ref_streak++;
        pend_owner = exp_ins_gnt ? 1 : ((exp_data_gnt && !data_we_i) ? 2 : 0);
        if (pend_owner != 0) pend_rdata = ref_read(exp_addr);
        if (exp_data_gnt && data_we_i)
            ref_mem[data_addr_i[31:2]] = merge(ref_read(data_addr_i), data_wdata_i, data_be_i);
        last_addr  = exp_addr;
        last_wdata = exp_wdata;
    endtask

    // Sample at the falling edge, then advance to just after the next rise.
    task automatic sample();
        @(negedge clk_i);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        ins_req_i    = 1'b0;
        ins_addr_i   = 32'h0;
        ins_flush_i  = 1'b0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({ins_gnt_o, data_gnt_o, ins_rvalid_o, data_rvalid_o, mem_en_o, mem_we_o} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got gnt=%b%b rvalid=%b%b en=%b we=%b expected all 0",
                     ins_gnt_o, data_gnt_o, ins_rvalid_o, data_rvalid_o, mem_en_o, mem_we_o);
        end
        checks++;
        if (mem_addr_o !== RST_ADDR || mem_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: got addr=%h wdata=%h expected %h / 0", mem_addr_o, mem_wdata_o, RST_ADDR);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_reset();

        // Load granted, then reset before its response appears.
        data_req_i  = 1'b1;
        data_addr_i = 32'h8000_0040;
        sample();
        checks++;
        if (data_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_load_gnt: got %b expected 1", data_gnt_o);
        end
        advance();
        rst_i      = 1'b1;
        data_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_reset();
        sample();
        checks++;
        if (data_rvalid_o !== 1'b0 || ins_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_midload_rvalid: got data=%b ins=%b expected 0 0", data_rvalid_o, ins_rvalid_o);
        end
        checks++;
        if (mem_en_o !== 1'b0 || mem_addr_o !== RST_ADDR) begin
            errors++;
            $display("FAIL reset_idle_mem: got en=%b addr=%h expected 0 %h", mem_en_o, mem_addr_o, RST_ADDR);
        end
        advance();
    endtask

    task automatic test_fetch_stream();
        logic [31:0] addrs [3];
        addrs[0] = 32'h8000_0000;
        addrs[1] = 32'h8000_0004;
        addrs[2] = 32'h8000_0008;
        for (int i = 0; i < 4; i++) begin
            ins_req_i  = (i < 3);
            ins_addr_i = (i < 3) ? addrs[i] : 32'h0;
            sample();
            checks++;
            if (ins_gnt_o !== (i < 3) || data_gnt_o !== 1'b0) begin
                errors++;
                $display("FAIL fetch_gnt[%0d]: got ins=%b data=%b expected %b 0", i, ins_gnt_o, data_gnt_o, i < 3);
            end
            checks++;
            if (ins_rvalid_o !== (i >= 1) || data_rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL fetch_rvalid[%0d]: got ins=%b data=%b expected %b 0", i, ins_rvalid_o, data_rvalid_o, i >= 1);
            end
            if (i >= 1) begin
                checks++;
                if (ins_rdata_o !== init_word(addrs[i-1])) begin
                    errors++;
                    $display("FAIL fetch_rdata[%0d]: got %h expected %h", i, ins_rdata_o, init_word(addrs[i-1]));
                end
            end
            advance();
        end
    endtask

    task automatic test_streak();
        logic exp_i;
        ins_req_i  = 1'b1;
        ins_addr_i = 32'h8000_0400;
        data_req_i = 1'b1;
        data_we_i  = 1'b0;
        data_addr_i = 32'h8000_0800;
        for (int i = 0; i < 15; i++) begin
            sample();
            exp_i = (i % (MAX + 1)) == MAX;
            checks++;
            if (ins_gnt_o !== exp_i || data_gnt_o !== !exp_i) begin
                errors++;
                $display("FAIL streak_seq[%0d]: got ins=%b data=%b expected %b %b", i, ins_gnt_o, data_gnt_o, exp_i, !exp_i);
            end
            checks++;
            if (ins_rvalid_o !== exp_ins_rvalid || data_rvalid_o !== exp_data_rvalid ||
                ((exp_ins_rvalid || exp_data_rvalid) && ins_rdata_o !== exp_rdata)) begin
                errors++;
                $display("FAIL streak_route[%0d]: got rv=%b%b rdata=%h expected rv=%b%b rdata=%h", i,
                         ins_rvalid_o, data_rvalid_o, ins_rdata_o, exp_ins_rvalid, exp_data_rvalid, exp_rdata);
            end
            advance();
            // New payload only once the previous one has been accepted.
            if (exp_ins_gnt) ins_addr_i = ins_addr_i + 32'd4;
            if (exp_data_gnt) begin
                data_we_i    = ($urandom_range(0, 2) == 0);
                data_be_i    = 4'($urandom_range(1, 15));
                data_wdata_i = $urandom;
                data_addr_i  = 32'h8000_0800 | (32'($urandom_range(0, 7)) << 2);
            end
        end
        idle_inputs();
        sample();
        advance();
    endtask

    task automatic test_store_load();
        logic [31:0] base, exp_w;
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'b0011;
        data_addr_i  = 32'h8000_0100;
        data_wdata_i = 32'hCAFE_BEEF;
        sample();
        checks++;
        if (data_gnt_o !== 1'b1 || mem_en_o !== 1'b1 || mem_we_o !== 4'b0011 ||
            mem_addr_o !== 32'h8000_0100 || mem_wdata_o !== 32'hCAFE_BEEF) begin
            errors++;
            $display("FAIL store_cmd: got gnt=%b en=%b we=%b addr=%h wdata=%h expected 1 1 0011 80000100 cafebeef",
                     data_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        advance();
        data_we_i = 1'b0;
        sample();
        checks++;
        if (data_rvalid_o !== 1'b0 || ins_rvalid_o !== 1'b0 || data_gnt_o !== 1'b1 || mem_we_o !== 4'b0) begin
            errors++;
            $display("FAIL store_no_rvalid: got rv=%b%b gnt=%b we=%b expected rv=00 gnt=1 we=0000",
                     ins_rvalid_o, data_rvalid_o, data_gnt_o, mem_we_o);
        end
        advance();
        idle_inputs();
        sample();
        base  = init_word(32'h8000_0100);
        exp_w = {base[31:16], 16'hBEEF};
        checks++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== exp_w) begin
            errors++;
            $display("FAIL load_after_store: got rv=%b rdata=%h expected 1 %h", data_rvalid_o, data_rdata_o, exp_w);
        end
        advance();
    endtask

    task automatic test_flush();
        ins_req_i  = 1'b1;
        ins_addr_i = 32'h8000_0200;
        sample();
        advance();
        ins_flush_i = 1'b1;
        ins_addr_i  = 32'h8000_0300;
        sample();
        checks++;
        if (ins_gnt_o !== 1'b1 || ins_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: got gnt=%b rvalid=%b expected 1 0", ins_gnt_o, ins_rvalid_o);
        end
        advance();
        idle_inputs();
        sample();
        checks++;
        if (ins_rvalid_o !== 1'b1 || ins_rdata_o !== init_word(32'h8000_0300)) begin
            errors++;
            $display("FAIL flush_keep_new: got rv=%b rdata=%h expected 1 %h",
                     ins_rvalid_o, ins_rdata_o, init_word(32'h8000_0300));
        end
        advance();

        // Flush next to a load response leaves the data port alone.
        data_req_i  = 1'b1;
        data_addr_i = 32'h8000_0500;
        sample();
        advance();
        idle_inputs();
        ins_flush_i = 1'b1;
        sample();
        checks++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== init_word(32'h8000_0500) || ins_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_data: got drv=%b rdata=%h irv=%b expected 1 %h 0",
                     data_rvalid_o, data_rdata_o, ins_rvalid_o, init_word(32'h8000_0500));
        end
        advance();
        ins_flush_i = 1'b0;
    endtask

    task automatic test_random();
        logic [72:0] obs_v, exp_v;
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            ins_flush_i = ($urandom_range(0, 5) == 0);
            sample();
            obs_v = {ins_gnt_o, data_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, ins_rvalid_o, data_rvalid_o};
            exp_v = {exp_ins_gnt, exp_data_gnt, exp_en, exp_we, exp_addr, exp_wdata, exp_ins_rvalid, exp_data_rvalid};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random_ctrl[%0d]: got %h expected %h (gnt,en,we,addr,wdata,rvalid)", i, obs_v, exp_v);
            end
            if (exp_ins_rvalid || exp_data_rvalid) begin
                checks++;
                if ((exp_ins_rvalid ? ins_rdata_o : data_rdata_o) !== exp_rdata) begin
                    errors++;
                    $display("FAIL random_rdata[%0d]: got %h expected %h", i,
                             exp_ins_rvalid ? ins_rdata_o : data_rdata_o, exp_rdata);
                end
            end
            advance();
            if (!ins_req_i || exp_ins_gnt) begin
                ins_req_i  = ($urandom_range(0, 3) != 0);
                ins_addr_i = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
            end
            if (!data_req_i || exp_data_gnt) begin
                data_req_i   = ($urandom_range(0, 3) != 0);
                data_we_i    = $urandom_range(0, 1) == 1;
                data_be_i    = 4'($urandom_range(0, 15));
                data_wdata_i = $urandom;
                data_addr_i  = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
            end
        end
        idle_inputs();
    endtask

    initial begin
        mem_rdata_i = 32'h0;
        model_reset();
        test_reset();
        test_fetch_stream();
        test_streak();
        test_store_load();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous simulation memory (1-cycle read latency) between the instruction-fetch requester and the load/store requester.
- Arbitrates one access per cycle and routes each read response back to the requester that owns it.
- Data port has priority, with a bounded-streak anti-starvation rule so fetch always makes progress.
- Supports fetch flush: an in-flight fetch response is discarded on a jump.

Parameters:
- MAX_DATA_STREAK, 4: maximum consecutive data grants while fetch is waiting before fetch is forced through; legal range 1..15.
- RESET_ADDR, 32'h8000_0000: value driven on mem_addr_o while idle and after reset.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- ins_req_i  input  1  fetch read request
- ins_addr_i  input  32  fetch word address
- ins_gnt_o  output  1  fetch request accepted this cycle
- ins_flush_i  input  1  discard any fetch response not yet delivered
- ins_rvalid_o  output  1  fetch read data valid
- ins_rdata_o  output  32  fetch read data
- data_req_i  input  1  load/store request
- data_we_i  input  1  1 = store, 0 = load
- data_be_i  input  4  store byte enables
- data_addr_i  input  32  load/store address
- data_wdata_i  input  32  store data
- data_gnt_o  output  1  data request accepted this cycle
- data_rvalid_o  output  1  load data valid
- data_rdata_o  output  32  load data
- mem_en_o  output  1  memory access this cycle
- mem_we_o  output  4  per-byte write strobe (0 for reads)
- mem_addr_o  output  32  memory address
- mem_wdata_o  output  32  memory write data
- mem_rdata_i  input  32  memory read data, valid the cycle after a read access

Behaviour:
- Reset (async, rst_i=1):
  - gnt, rvalid, mem_en_o and mem_we_o all 0.
  - mem_addr_o = RESET_ADDR; mem_wdata_o = 0.
  - owner register = NONE; streak counter = 0; priority state = PRIO_DATA.
  - Reset mid-access drops any pending response: no rvalid in the first cycle after reset release.
- Grant is combinational, same cycle; at most one of ins_gnt_o or data_gnt_o is high per cycle. Requesters hold req and payload stable until granted.
- Priority state machine:
  - PRIO_DATA:
    - data_req_i wins if asserted.
    - If both requesters are active and data is granted, the streak counter increments.
    - When the counter reaches MAX_DATA_STREAK with ins_req_i still high, go to PRIO_INS next cycle.
    - Any fetch grant clears the counter to 0.
    - A cycle with ins_req_i low also clears the counter.
  - PRIO_INS:
    - ins_req_i wins if asserted.
    - After one fetch grant, or when ins_req_i is low, return to PRIO_DATA with counter = 0.
- Memory drive: the granted requester's address, we and be are muxed onto mem_*.
  - Fetch: mem_we_o = 0.
  - Store: mem_we_o = data_be_i.
  - Load: mem_we_o = 0.
  - No grant: mem_en_o = 0 and mem_we_o = 0; address and wdata hold their last values.
- Response routing:
  - owner register <= INS on a fetch grant, DATA on a load grant, NONE on a store grant or no grant.
  - Next cycle: owner INS gives ins_rvalid_o = 1; owner DATA gives data_rvalid_o = 1.
  - ins_rdata_o and data_rdata_o are both driven by mem_rdata_i; only the matching rvalid qualifies it.
  - Stores produce no rvalid.
- Latency: exactly 1 cycle from grant to rvalid. Back-to-back grants are fully pipelined, 1 access per cycle.
- Flush:
  - ins_flush_i=1 in a cycle where owner = INS forces ins_rvalid_o = 0 that cycle.
  - A fetch grant in the same cycle as a flush is the post-jump request; it is kept and its response is delivered.
  - Flush never affects data-port traffic.
- Streak counter saturates at MAX_DATA_STREAK and never wraps.
- A single requester alone gets a grant every cycle; there are no bubbles.

Decomposition:
- Package mem_arb_pkg:
  - enum resp_owner_e {OWNER_NONE, OWNER_INS, OWNER_DATA}
  - enum arb_state_e {PRIO_DATA, PRIO_INS}
  - localparam STREAK_W = 4
- No sub-module. The grant logic, streak counter and owner register stay in one module (~150-250 lines).

Test Plan:
- Reset then idle:
  - Required: all gnt/rvalid = 0, mem_en_o = 0, mem_addr_o = 32'h8000_0000.
  - Assert rst_i mid-load: no data_rvalid_o after release.
- Fetch only, ins_addr_i = 8000_0000, 8000_0004, 8000_0008 on consecutive cycles:
  - Required: ins_gnt_o = 1 each cycle.
  - Required: ins_rvalid_o = 1 in cycles 2-4 with the matching mem_rdata_i; data_rvalid_o never set.
- Both requesting continuously, MAX_DATA_STREAK = 4:
  - Required grant sequence: D, D, D, D, I, D, D, D, D, I, ...
  - Required: rvalid routed to the correct port each cycle.
- Store with data_be_i = 4'b0011 to 8000_0100:
  - Required: mem_we_o = 4'b0011, no rvalid.
  - A following load of 8000_0100 returns data_rvalid_o = 1 one cycle after its grant.
- Fetch granted in cycle N, ins_flush_i = 1 in N+1, with a new fetch granted in N+1:
  - Required: ins_rvalid_o = 0 in N+1, ins_rvalid_o = 1 in N+2 with the new address's data.
- Load granted in cycle N, ins_flush_i = 1 in N+1:
  - Required: data_rvalid_o = 1 in N+1 (unaffected).
